// File: rtl/spi_buf_pkg.sv
// ============================================================================
//  Module      : spi_buf_pkg
//  Description : Shared sizing constants, error-bit indices and the sticky
//                error-flag update helper for the SPI byte buffer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_buf_pkg;

    localparam int SPI_BUF_DEPTH = 16;
    localparam int SPI_BUF_AW    = 4;

    localparam int ERR_TX_OVF = 0;
    localparam int ERR_TX_UDF = 1;
    localparam int ERR_RX_OVF = 2;
    localparam int ERR_W      = 3;

    typedef struct packed {
        logic rx_ovf;
        logic tx_udf;
        logic tx_ovf;
    } err_t;

    // A same-cycle event beats the clear, so a fresh error is never lost.
    function automatic err_t err_update(input err_t cur, input err_t ev, input logic clr);
        err_t base;
        base = clr ? err_t'('0) : cur;
        return base | ev;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_fifo.sv
// ============================================================================
//  Module      : spi_sync_fifo
//  Description : Single-clock byte FIFO with show-ahead read, fill count,
//                flush, and overflow/underrun event pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_wr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd,
    output logic [7:0]    o_rd_data,
    output logic [AW:0]   o_cnt,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ovf,
    output logic          o_udf
);

    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;

    logic w_rd_ok;
    logic w_wr_ok;
    logic w_pop;
    logic w_push;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // when it is also being read.
    assign w_rd_ok = i_rd && (r_cnt != '0);
    assign w_wr_ok = i_wr && ((r_cnt != c_DEPTH_CNT) || w_rd_ok);
    assign w_pop   = w_rd_ok && !i_flush;
    assign w_push  = w_wr_ok && !i_flush;

    assign o_ovf = i_wr && !w_wr_ok && !i_flush;
    assign o_udf = i_rd && (r_cnt == '0) && !i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = (r_cnt != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign o_cnt     = r_cnt;
    assign o_full    = (r_cnt == c_DEPTH_CNT);
    assign o_empty   = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/spi_byte_buf.sv
// ============================================================================
//  Module      : spi_byte_buf
//  Description : TX/RX byte FIFO pair between the host side and spi_master,
//                with fill levels, flush and sticky error flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_byte_buf
    import spi_buf_pkg::*;
#(
    parameter int DEPTH = SPI_BUF_DEPTH,
    parameter int AW    = SPI_BUF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          err_clr,
    input  logic          host_tx_wr,
    input  logic [7:0]    host_tx_data,
    output logic          host_tx_full,
    output logic [AW:0]   host_tx_cnt,
    input  logic          host_rx_rd,
    output logic [7:0]    host_rx_data,
    output logic          host_rx_empty,
    output logic [AW:0]   host_rx_cnt,
    output logic          tx_buf_vld,
    output logic [7:0]    tx_buf_byte,
    input  logic          tx_buf_req,
    output logic          rx_buf_vld,
    input  logic          rx_buf_req,
    input  logic [7:0]    rx_buf_byte,
    output logic [2:0]    err_status
);

    logic w_tx_empty;
    logic w_tx_ovf;
    logic w_tx_udf;
    logic w_rx_full;
    logic w_rx_ovf;
    err_t w_err_ev;
    err_t r_err;

    spi_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_wr      (host_tx_wr),
        .i_wr_data (host_tx_data),
        .i_rd      (tx_buf_req),
        .o_rd_data (tx_buf_byte),
        .o_cnt     (host_tx_cnt),
        .o_full    (host_tx_full),
        .o_empty   (w_tx_empty),
        .o_ovf     (w_tx_ovf),
        .o_udf     (w_tx_udf)
    );

    // A host read of an empty RX FIFO is silently ignored, so its underrun
    // pulse is left unconnected.
    spi_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_wr      (rx_buf_req),
        .i_wr_data (rx_buf_byte),
        .i_rd      (host_rx_rd),
        .o_rd_data (host_rx_data),
        .o_cnt     (host_rx_cnt),
        .o_full    (w_rx_full),
        .o_empty   (host_rx_empty),
        .o_ovf     (w_rx_ovf),
        .o_udf     ()
    );

    assign tx_buf_vld = !w_tx_empty;
    assign rx_buf_vld = !w_rx_full;

    always_comb begin
        w_err_ev        = '0;
        w_err_ev.tx_ovf = w_tx_ovf;
        w_err_ev.tx_udf = w_tx_udf;
        w_err_ev.rx_ovf = w_rx_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= err_update(r_err, w_err_ev, err_clr);
        end
    end

    assign err_status = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_buf.sv
// ============================================================================
//  Module      : tb_spi_byte_buf
//  Description : Self-checking bench for spi_byte_buf: directed scenarios plus
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_byte_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst, flush, err_clr;
    logic          host_tx_wr, host_rx_rd, tx_buf_req, rx_buf_req;
    logic [7:0]    host_tx_data, rx_buf_byte;
    logic          host_tx_full, host_rx_empty, tx_buf_vld, rx_buf_vld;
    logic [AW:0]   host_tx_cnt, host_rx_cnt;
    logic [7:0]    host_rx_data, tx_buf_byte;
    logic [2:0]    err_status;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [2:0] m_err;

    always #5 clk = ~clk;

    spi_byte_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .err_clr       (err_clr),
        .host_tx_wr    (host_tx_wr),
        .host_tx_data  (host_tx_data),
        .host_tx_full  (host_tx_full),
        .host_tx_cnt   (host_tx_cnt),
        .host_rx_rd    (host_rx_rd),
        .host_rx_data  (host_rx_data),
        .host_rx_empty (host_rx_empty),
        .host_rx_cnt   (host_rx_cnt),
        .tx_buf_vld    (tx_buf_vld),
        .tx_buf_byte   (tx_buf_byte),
        .tx_buf_req    (tx_buf_req),
        .rx_buf_vld    (rx_buf_vld),
        .rx_buf_req    (rx_buf_req),
        .rx_buf_byte   (rx_buf_byte),
        .err_status    (err_status)
    );

    task automatic idle_inputs();
        rst = 0; flush = 0; err_clr = 0;
        host_tx_wr = 0; host_tx_data = 8'h00; host_rx_rd = 0;
        tx_buf_req = 0; rx_buf_req = 0; rx_buf_byte = 8'h00;
    endtask

    // One clock edge; the reference model consumes the inputs present at it.
    task automatic step();
        bit tpop, tpush, rpop, rpush;
        logic [2:0] ev;
        @(posedge clk);
        if (rst) begin
            txq.delete(); rxq.delete(); m_err = 3'b000;
        end else if (flush) begin
            txq.delete(); rxq.delete();
            if (err_clr) m_err = 3'b000;
        end else begin
            tpop  = tx_buf_req && (txq.size() > 0);
            tpush = host_tx_wr && ((txq.size() < DEPTH) || tpop);
            rpop  = host_rx_rd && (rxq.size() > 0);
            rpush = rx_buf_req && ((rxq.size() < DEPTH) || rpop);
            ev[0] = host_tx_wr && !tpush;
            ev[1] = tx_buf_req && (txq.size() == 0);
            ev[2] = rx_buf_req && !rpush;
            if (tpop)  void'(txq.pop_front());
            if (tpush) txq.push_back(host_tx_data);
            if (rpop)  void'(rxq.pop_front());
            if (rpush) rxq.push_back(rx_buf_byte);
            m_err = (err_clr ? 3'b000 : m_err) | ev;
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1; step(); rst = 0;
        checks++;
        if (host_tx_cnt !== 5'd0 || host_rx_cnt !== 5'd0) begin
            errors++; $display("FAIL reset_cnt tx=%0d rx=%0d expected 0/0", host_tx_cnt, host_rx_cnt);
        end
        checks++;
        if ({tx_buf_vld, host_tx_full, host_rx_empty, rx_buf_vld} !== 4'b0011) begin
            errors++; $display("FAIL reset_status got %b expected 0011", {tx_buf_vld, host_tx_full, host_rx_empty, rx_buf_vld});
        end
        checks++;
        if (err_status !== 3'b000 || tx_buf_byte !== 8'h00 || host_rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data err=%b txb=%h rxd=%h expected 0", err_status, tx_buf_byte, host_rx_data);
        end
    endtask

    task automatic test_tx_single();
        host_tx_wr = 1; host_tx_data = 8'h55; step(); host_tx_wr = 0;
        checks++;
        if (tx_buf_vld !== 1'b1 || tx_buf_byte !== 8'h55) begin
            errors++; $display("FAIL tx_single_vld vld=%b byte=%h expected 1/55", tx_buf_vld, tx_buf_byte);
        end
        tx_buf_req = 1; step(); tx_buf_req = 0;
        checks++;
        if (tx_buf_vld !== 1'b0 || host_tx_cnt !== 5'd0) begin
            errors++; $display("FAIL tx_single_pop vld=%b cnt=%0d expected 0/0", tx_buf_vld, host_tx_cnt);
        end
    endtask

    task automatic test_tx_fill();
        for (int i = 0; i < 16; i++) begin
            host_tx_wr = 1; host_tx_data = 8'(i); step();
        end
        checks++;
        if (host_tx_full !== 1'b1 || host_tx_cnt !== 5'd16) begin
            errors++; $display("FAIL tx_full full=%b cnt=%0d expected 1/16", host_tx_full, host_tx_cnt);
        end
        host_tx_data = 8'hAA; step(); host_tx_wr = 0;
        checks++;
        if (err_status[0] !== 1'b1 || host_tx_cnt !== 5'd16) begin
            errors++; $display("FAIL tx_ovf err=%b cnt=%0d expected x_x1/16", err_status, host_tx_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tx_buf_byte !== 8'(i)) begin
                errors++; $display("FAIL tx_order[%0d] got %h expected %h", i, tx_buf_byte, 8'(i));
            end
            tx_buf_req = 1; step();
        end
        tx_buf_req = 0;
        checks++;
        if (host_tx_cnt !== 5'd0 || tx_buf_vld !== 1'b0) begin
            errors++; $display("FAIL tx_drain cnt=%0d vld=%b expected 0/0", host_tx_cnt, tx_buf_vld);
        end
        err_clr = 1; step(); err_clr = 0;
        for (int i = 0; i < 8; i++) begin
            host_tx_wr = 1; host_tx_data = 8'h20 + 8'(i); step();
        end
        host_tx_wr = 0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_buf_byte !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL tx_wrap[%0d] got %h expected %h", i, tx_buf_byte, 8'h20 + 8'(i));
            end
            tx_buf_req = 1; step();
        end
        tx_buf_req = 0;
    endtask

    task automatic test_rx_fill();
        for (int i = 0; i < 16; i++) begin
            rx_buf_req = 1; rx_buf_byte = 8'h10 + 8'(i); step();
        end
        checks++;
        if (rx_buf_vld !== 1'b0 || host_rx_cnt !== 5'd16) begin
            errors++; $display("FAIL rx_full vld=%b cnt=%0d expected 0/16", rx_buf_vld, host_rx_cnt);
        end
        rx_buf_byte = 8'h99; step(); rx_buf_req = 0;
        checks++;
        if (err_status[2] !== 1'b1 || host_rx_cnt !== 5'd16) begin
            errors++; $display("FAIL rx_ovf err=%b cnt=%0d expected 1xx/16", err_status, host_rx_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (host_rx_data !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL rx_order[%0d] got %h expected %h", i, host_rx_data, 8'h10 + 8'(i));
            end
            host_rx_rd = 1; step();
        end
        host_rx_rd = 0;
        err_clr = 1; step(); err_clr = 0;
        checks++;
        if (err_status !== 3'b000 || host_rx_empty !== 1'b1) begin
            errors++; $display("FAIL rx_errclr err=%b empty=%b expected 000/1", err_status, host_rx_empty);
        end
    endtask

    task automatic test_tx_udf();
        tx_buf_req = 1; step(); tx_buf_req = 0;
        checks++;
        if (err_status !== 3'b010 || host_tx_cnt !== 5'd0 || tx_buf_vld !== 1'b0) begin
            errors++; $display("FAIL tx_udf err=%b cnt=%0d vld=%b expected 010/0/0", err_status, host_tx_cnt, tx_buf_vld);
        end
        // Clear and raise in the same cycle: the new event must win.
        err_clr = 1; tx_buf_req = 1; step(); tx_buf_req = 0;
        checks++;
        if (err_status !== 3'b010) begin
            errors++; $display("FAIL clr_vs_event err=%b expected 010", err_status);
        end
        step(); err_clr = 0;
    endtask

    task automatic test_simul();
        for (int i = 0; i < 16; i++) begin
            host_tx_wr = 1; host_tx_data = 8'h40 + 8'(i); step();
        end
        host_tx_data = 8'h77; tx_buf_req = 1; step();
        host_tx_wr = 0; tx_buf_req = 0;
        checks++;
        if (host_tx_cnt !== 5'd16 || err_status[0] !== 1'b0) begin
            errors++; $display("FAIL simul_tx cnt=%0d err=%b expected 16/xx0", host_tx_cnt, err_status);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 15) ? 8'h41 + 8'(i) : 8'h77;
            checks++;
            if (tx_buf_byte !== exp_b) begin
                errors++; $display("FAIL simul_order[%0d] got %h expected %h", i, tx_buf_byte, exp_b);
            end
            tx_buf_req = 1; step();
        end
        tx_buf_req = 0;
        rx_buf_req = 1; rx_buf_byte = 8'h3C; host_rx_rd = 1; step();
        rx_buf_req = 0; host_rx_rd = 0;
        checks++;
        if (host_rx_cnt !== 5'd1 || host_rx_data !== 8'h3C) begin
            errors++; $display("FAIL simul_rx cnt=%0d head=%h expected 1/3c", host_rx_cnt, host_rx_data);
        end
        host_rx_rd = 1; step(); host_rx_rd = 0;
    endtask

    task automatic load_5_3();
        for (int i = 0; i < 5; i++) begin
            host_tx_wr = 1; host_tx_data = 8'($urandom);
            rx_buf_req = (i < 3); rx_buf_byte = 8'($urandom);
            step();
        end
        host_tx_wr = 0; rx_buf_req = 0;
    endtask

    task automatic test_flush();
        err_clr = 1; step(); err_clr = 0;
        tx_buf_req = 1; step(); tx_buf_req = 0;
        load_5_3();
        checks++;
        if (host_tx_cnt !== 5'd5 || host_rx_cnt !== 5'd3) begin
            errors++; $display("FAIL flush_pre tx=%0d rx=%0d expected 5/3", host_tx_cnt, host_rx_cnt);
        end
        flush = 1; host_tx_wr = 1; rx_buf_req = 1; tx_buf_req = 1; step();
        flush = 0; host_tx_wr = 0; rx_buf_req = 0; tx_buf_req = 0;
        checks++;
        if (host_tx_cnt !== 5'd0 || host_rx_cnt !== 5'd0 || tx_buf_vld !== 1'b0 || rx_buf_vld !== 1'b1 || err_status !== 3'b010) begin
            errors++; $display("FAIL flush tx=%0d rx=%0d vld=%b rvld=%b err=%b expected 0/0/0/1/010",
                               host_tx_cnt, host_rx_cnt, tx_buf_vld, rx_buf_vld, err_status);
        end
        load_5_3();
        rst = 1; host_tx_wr = 1; rx_buf_req = 1; step();
        rst = 0; host_tx_wr = 0; rx_buf_req = 0;
        checks++;
        if (host_tx_cnt !== 5'd0 || host_rx_cnt !== 5'd0 || tx_buf_vld !== 1'b0 || rx_buf_vld !== 1'b1 || err_status !== 3'b000) begin
            errors++; $display("FAIL rst_mid tx=%0d rx=%0d vld=%b rvld=%b err=%b expected 0/0/0/1/000",
                               host_tx_cnt, host_rx_cnt, tx_buf_vld, rx_buf_vld, err_status);
        end
    endtask

    task automatic test_random();
        int p_tx_in, p_tx_out, p_rx_in, p_rx_out;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                p_tx_in  = $urandom_range(10, 90); p_tx_out = $urandom_range(10, 90);
                p_rx_in  = $urandom_range(10, 90); p_rx_out = $urandom_range(10, 90);
            end
            rst          = ($urandom_range(0, 499) == 0);
            flush        = ($urandom_range(0, 99) == 0);
            err_clr      = ($urandom_range(0, 29) == 0);
            host_tx_wr   = ($urandom_range(0, 99) < p_tx_in);
            host_tx_data = 8'($urandom);
            tx_buf_req   = ($urandom_range(0, 99) < p_tx_out);
            rx_buf_req   = ($urandom_range(0, 99) < p_rx_in);
            rx_buf_byte  = 8'($urandom);
            host_rx_rd   = ($urandom_range(0, 99) < p_rx_out);
            step();
            checks++;
            if (host_tx_cnt !== (AW+1)'(txq.size()) || host_rx_cnt !== (AW+1)'(rxq.size())) begin
                errors++; $display("FAIL rand_cnt c=%0d tx=%0d rx=%0d expected %0d/%0d",
                                   c, host_tx_cnt, host_rx_cnt, txq.size(), rxq.size());
            end
            checks++;
            if ({tx_buf_vld, host_tx_full, host_rx_empty, rx_buf_vld} !==
                {txq.size() != 0, txq.size() == DEPTH, rxq.size() == 0, rxq.size() != DEPTH}) begin
                errors++; $display("FAIL rand_status c=%0d got %b", c, {tx_buf_vld, host_tx_full, host_rx_empty, rx_buf_vld});
            end
            checks++;
            if (err_status !== m_err) begin
                errors++; $display("FAIL rand_err c=%0d got %b expected %b", c, err_status, m_err);
            end
            if (txq.size() != 0) begin
                checks++;
                if (tx_buf_byte !== txq[0]) begin
                    errors++; $display("FAIL rand_txb c=%0d got %h expected %h", c, tx_buf_byte, txq[0]);
                end
            end
            if (rxq.size() != 0) begin
                checks++;
                if (host_rx_data !== rxq[0]) begin
                    errors++; $display("FAIL rand_rxd c=%0d got %h expected %h", c, host_rx_data, rxq[0]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_err = 3'b000;
        idle_inputs();
        test_reset();
        test_tx_single();
        test_tx_fill();
        test_rx_fill();
        test_tx_udf();
        test_simul();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/spi_byte_buf.md
Name: spi_byte_buf

Overview:
- Dual byte FIFO placed between the host/register side and spi_master.
- The TX FIFO feeds spi_master through its tx_buf_vld/tx_buf_byte/tx_buf_req handshake.
- The RX FIFO collects bytes delivered by spi_master through its rx_buf_vld/rx_buf_req/rx_buf_byte handshake.
- Provides fill levels, flush, and sticky overflow/underrun flags to the host.

Parameters:
- DEPTH, 16: entries per FIFO; must be a power of 2, minimum 2.
- AW, 4: log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  empty both FIFOs (pointers/counts to 0).
- err_clr  in  1  clear all sticky error flags.
- host_tx_wr  in  1  push host_tx_data into TX FIFO.
- host_tx_data  in  8  byte to transmit.
- host_tx_full  out  1  TX count == DEPTH.
- host_tx_cnt  out  AW+1  TX fill level.
- host_rx_rd  in  1  pop RX FIFO head.
- host_rx_data  out  8  RX head byte (show-ahead).
- host_rx_empty  out  1  RX count == 0.
- host_rx_cnt  out  AW+1  RX fill level.
- tx_buf_vld  out  1  TX head byte available to spi_master.
- tx_buf_byte  out  8  TX head byte (show-ahead).
- tx_buf_req  in  1  single-cycle pulse: spi_master consumed the head byte.
- rx_buf_vld  out  1  RX FIFO can accept one byte.
- rx_buf_req  in  1  single-cycle pulse: rx_buf_byte is valid; write it.
- rx_buf_byte  in  8  received byte.
- err_status  out  3  {rx_ovf, tx_udf, tx_ovf}, sticky.

Behaviour:
- Reset (rst=1 at clk edge):
  - All pointers and counts are 0.
  - tx_buf_vld=0, host_tx_full=0, host_rx_empty=1, rx_buf_vld=1.
  - err_status=0, data outputs=0.
- Memory is written at the clock edge; storage contents are not reset.
- Data outputs are combinational reads of the head entry, valid whenever count>0.
- Status outputs derive from registered counts, so they update the cycle after the causing edge:
  - tx_buf_vld = (tx_cnt != 0)
  - rx_buf_vld = (rx_cnt != DEPTH)
  - host_tx_full = (tx_cnt == DEPTH)
  - host_rx_empty = (rx_cnt == 0)
- TX push:
  - Accepted when host_tx_wr && (!full || pop in same cycle).
  - host_tx_wr while full with no pop: byte dropped, tx_ovf set.
- TX pop:
  - Occurs on tx_buf_req && tx_cnt != 0.
  - tx_buf_req with tx_cnt == 0: no pointer change, tx_udf set.
- Back-to-back tx_buf_req pulses on consecutive cycles each pop one byte. Latency from push to tx_buf_vld=1 is 1 cycle.
- RX push:
  - Accepted on rx_buf_req && (!full || host_rx_rd pop same cycle).
  - Otherwise the byte is dropped and rx_ovf is set.
- RX pop: host_rx_rd && rx_cnt != 0. host_rx_rd when empty is ignored, with no flag.
- Simultaneous push+pop on one FIFO:
  - Count is unchanged; both pointers advance.
  - Valid at cnt 0 only if the push is accepted. Pop at empty is not performed, so count becomes 1.
- Pointers are AW bits and wrap modulo DEPTH. Counts are AW+1 bits and saturate naturally at DEPTH.
- flush:
  - Has priority over the same-cycle push/pop on both FIFOs; those operations are discarded.
  - Flags are not touched, except that overflow/underrun events in the flush cycle are not flagged.
- err_clr:
  - Clears flags.
  - A new error event in the same cycle wins; the flag remains set.
- Priority: rst > flush > push/pop.
- Reset mid-transfer: state returns to reset values within one cycle. spi_master sees tx_buf_vld=0 from the next cycle.

Decomposition:
- Package spi_buf_pkg holds:
  - SPI_BUF_DEPTH=16
  - SPI_BUF_AW=4
  - ERR_TX_OVF=0, ERR_TX_UDF=1, ERR_RX_OVF=2 (bit indices)
- Natural sub-module: spi_sync_fifo (DEPTH, AW; wr/wr_data/rd/rd_data/cnt/flush/ovf/udf pulse outputs).
  - Instantiated twice, once for TX and once for RX.
  - The top level holds the sticky flags and handshake mapping.

Test Plan:
- Push 0x55, then idle:
  - tx_buf_vld=1 and tx_buf_byte=0x55 one cycle after push.
  - tx_buf_req pulse: tx_buf_vld=0 next cycle, host_tx_cnt=0.
- Push 0x00..0x0F (16 bytes):
  - host_tx_full=1, host_tx_cnt=16.
  - 17th push of 0xAA is dropped; err_status[0]=1.
  - 16 req pulses read out 0x00..0x0F in order. Pointer wrap is then checked with 8 more bytes 0x20..0x27.
- rx_buf_req with bytes 0x10..0x1F:
  - rx_buf_vld=0 after the 16th.
  - 17th req (0x99) is dropped; err_status[2]=1.
  - host reads return 0x10..0x1F; err_clr clears err_status to 0.
- tx_buf_req with TX empty: err_status[1]=1, host_tx_cnt stays 0, tx_buf_vld stays 0.
- Simultaneous ops:
  - TX full plus host_tx_wr(0x77) and tx_buf_req in one cycle: cnt stays 16, no tx_ovf, 0x77 emerges last.
  - RX empty with rx_buf_req(0x3C) and host_rx_rd: rx_cnt=1, head=0x3C.
- TX cnt=5, RX cnt=3, assert flush with a concurrent push: both counts 0, tx_buf_vld=0, rx_buf_vld=1, flags unchanged. Repeat with rst=1 instead of flush: err_status=0 as well.
